// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK up/down counter: direction encodings,
// default width and the all-ones helper macro.

`ifndef JK_UPDOWN_COUNTER_DEFS
`define JK_UPDOWN_COUNTER_DEFS
// All-ones value of a given width, e.g. `CNT_ALL_ONES(4) == 4'b1111.
`define CNT_ALL_ONES(w) {(w){1'b1}}
`endif

package jk_updown_counter_pkg;

    // Direction encodings for up_dn.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Default number of JK stages.
    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/jk_updown_counter_jk_ff_ar.sv
// Single JK flip-flop stage with asynchronous active-high reset.
// JK = 00 hold, 01 reset, 10 set, 11 toggle.

module jk_ff_ar (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    logic r_q;

    // JK state update; reset clears the stage immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   r_q <= r_q;
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                default: r_q <= ~r_q;
            endcase
        end
    end

    assign q  = r_q;
    assign qn = ~r_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Synchronous up/down binary counter built from WIDTH JK stages.
// The top holds only the J/K steering (load mux, up/down AND chains)
// and the terminal-count decode; all stages share clk, so no ripple.
// Priority: rst > load > en > hold.

module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qn;
    logic [WIDTH-1:0] w_all1;   // w_all1[i] = AND of q[i-1:0]
    logic [WIDTH-1:0] w_all0;   // w_all0[i] = AND of ~q[i-1:0]
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_dir_up;
    logic             w_dir_dn;

    assign w_dir_up = (up_dn == DIR_UP);
    assign w_dir_dn = (up_dn == DIR_DN);

    // Prefix AND chains over lower bits for both directions.
    always_comb begin
        w_all1    = '0;
        w_all0    = '0;
        w_all1[0] = 1'b1;
        w_all0[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_all1[i] = w_all1[i-1] & w_q[i-1];
            w_all0[i] = w_all0[i-1] & w_qn[i-1];
        end
    end

    // Toggle enables and J/K steering: load forces J=d, K=~d; otherwise J=K=T.
    always_comb begin
        w_t = '0;
        w_j = '0;
        w_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_t[i] = en & (w_dir_up ? w_all1[i] : w_all0[i]);
            if (load) begin
                w_j[i] = d[i];
                w_k[i] = ~d[i];
            end else begin
                w_j[i] = w_t[i];
                w_k[i] = w_t[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            jk_ff_ar u_ff (
                .clk (clk),
                .rst (rst),
                .j   (w_j[gi]),
                .k   (w_k[gi]),
                .q   (w_q[gi]),
                .qn  (w_qn[gi])
            );
        end
    endgenerate

    assign q  = w_q;
    assign qn = w_qn;

    // Terminal count: next enabled step wraps; masked while reset is held.
    assign tc = ~rst & en &
                ((w_dir_up & (w_q == `CNT_ALL_ONES(WIDTH))) |
                 (w_dir_dn & (w_q == '0)));

endmodule

// File: doc/jk_updown_counter.md
# jk_updown_counter

- Synchronous up/down binary counter built from per-bit JK flip-flops with async reset; default width 4.
- Counts up or down depending on a direction input. Supports synchronous parallel load and count enable, and flags the terminal count.
- Complements the existing up-only JK counter path: reaches the same states in the reverse direction. Used wherever the design needs a decrementing or reversible count.

## Interface
- `WIDTH`, default 4 — number of JK stages and the count width (legal range 2..16).
- `clk` input 1 — clock; all state changes on the rising edge.
- `rst` input 1 — asynchronous, active-high reset; forces count to 0 immediately.
- `en` input 1 — count enable; 1 = step by one on the next edge.
- `up_dn` input 1 — direction: 1 = increment, 0 = decrement; sampled each edge.
- `load` input 1 — synchronous parallel load of `d`.
- `d` input WIDTH — load value.
- `q` output WIDTH — current count.
- `qn` output WIDTH — bitwise complement of `q`.
- `tc` output 1 — terminal count, combinational: 1 when `en`=1 and either `up_dn`=1 with `q`=all-ones, or `up_dn`=0 with `q`=0.

## Operation
- **Priority:** `rst` > `load` > `en` > hold.
- **Reset:** `q`=0, `qn`=all-ones, `tc`=0 while `rst` is high (`en` is irrelevant, since `q`=0 with up_dn=0 is masked by reset). Reset asserted mid-count clears `q` immediately without waiting for an edge. After deassertion, the first edge counts normally.
- **Load:** every stage gets J=`d[i]`, K=~`d[i]`, so `q`=`d` after the edge regardless of `en` and `up_dn`.
- **Count up:** stage i has J=K=T_i, where T_0=`en` and T_i = `en` AND all of `q[i-1:0]`.
- **Count down:** same structure, but T_i = `en` AND all of ~`q[i-1:0]`.
- **Hold:** `en`=0 and `load`=0 gives J=K=0 on every stage, so `q` is unchanged.
- **Wrap-around:**
  - Up from all-ones goes to 0.
  - Down from 0 goes to all-ones.
  - `tc` is high in the cycle before the wrapping edge.
- **Direction change:** takes effect on the same edge where the new `up_dn` is sampled. No dead cycle, no glitch state.
- **Arithmetic:** all counting is modulo 2^WIDTH. There are no saturating modes.
- `qn` is always the exact complement of `q`, including during reset.

## Timing
- Single clock domain; every flip-flop shares `clk`, so there is no ripple.
- Count latency: `q` updates 1 cycle after `en` is sampled high.
- Load latency: 1 cycle.
- `tc` is combinational from `q`, `en` and `up_dn`; its path depth is one WIDTH-input AND.
- The T_i AND chains are combinational within one cycle and must meet the clock period at WIDTH=16.
- Reset-to-output is asynchronous; there is no clock requirement during reset.

## Structure
- **Shared header `counter_defs`:**
  - Direction encodings `DIR_UP`=1 and `DIR_DN`=0.
  - Default width of 4.
  - Macro for the all-ones value of a given width.
- **Sub-module `jk_ff_ar`:** a single JK stage with async active-high reset.
  - Ports `clk`, `rst`, `j`, `k`, `q`, `qn`.
  - Behaviour: JK=00 hold, 01 reset, 10 set, 11 toggle.
  - Instantiated WIDTH times by a generate loop.
- **Top level contents:** only the T/J/K steering logic (load mux, up/down AND chains) and the `tc` decode.

## Test plan
- **Reset:** assert `rst` with `q`=4'b1010 between edges → `q`=0 and `qn`=4'b1111 immediately. Deassert, then `en`=1, `up_dn`=1 for 3 edges → `q`=3.
- **Up wrap:** load 4'hE, then count up for 2 edges → `q` sequence E, F, 0. `tc`=1 only while `q`=F.
- **Down wrap:** load 4'h1, then count down for 3 edges → `q` sequence 1, 0, F, E. `tc`=1 only while `q`=0.
- **Priority and hold:** `load`=1, `d`=4'h7, `en`=1, `up_dn`=0 → `q`=7, not a decrement. Then `en`=0 for 5 edges → `q` stays 7 and `tc`=0.
- **Direction reversal:** from `q`=5, sequence up, up, down, down, down on consecutive edges → 6, 7, 6, 5, 4.
- **Full-cycle check:** WIDTH=8, count up 256 edges from 0 → returns to 0. Check `qn`==~`q` every cycle.
